// File: rtl/sprite_draw_engine.sv
// Sprite position keeper and box erase/redraw sweeper for the VGA plotter, one pixel per clock.
// Optional border colouring during DRAW is enabled by defining SPRITE_BORDER_EN.
module sprite_draw_engine #(
  parameter int unsigned SCREEN_W  = 160,
  parameter int unsigned SCREEN_H  = 120,
  parameter int unsigned BOX       = 4,
  parameter int unsigned STEP      = 1,
  parameter int unsigned X_INIT    = 78,
  parameter int unsigned Y_INIT    = 58,
  parameter logic [2:0]  BG_COLOUR = 3'b000,
  parameter logic [2:0]  FG_COLOUR = 3'b111,
  parameter logic [2:0]  BD_COLOUR = 3'b100
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] cmd,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_col,
  output logic       plot,
  output logic       done_o,
  output logic [7:0] pos_x,
  output logic [6:0] pos_y
);

  localparam int unsigned NPix = BOX * BOX;
  localparam int unsigned CntW = $clog2(NPix + 1);

  localparam logic [7:0] XMax  = 8'(SCREEN_W - BOX);
  localparam logic [6:0] YMax  = 7'(SCREEN_H - BOX);
  localparam logic [7:0] StepX = 8'(STEP);
  localparam logic [6:0] StepY = 7'(STEP);

  localparam logic [3:0] CmdPrehold = 4'b0100;
  localparam logic [3:0] CmdHold    = 4'b0000;
  localparam logic [3:0] CmdClear   = 4'b0001;
  localparam logic [3:0] CmdLeft    = 4'b0011;
  localparam logic [3:0] CmdRight   = 4'b0010;
  localparam logic [3:0] CmdDown    = 4'b0110;
  localparam logic [3:0] CmdUp      = 4'b0111;
  localparam logic [3:0] CmdDraw    = 4'b0101;

`ifdef SPRITE_BORDER_EN
  localparam bit BorderEn = 1'b1;
`else
  localparam bit BorderEn = 1'b0;
`endif

  typedef enum logic [0:0] {StIdle, StSweep} state_e;

  state_e          state_q;
  logic [3:0]      cmd_q;
  logic [3:0]      swept_q;
  logic [CntW-1:0] cnt_q;
  logic            done_q;
  logic            plot_q;
  logic [7:0]      vga_x_q;
  logic [6:0]      vga_y_q;
  logic [2:0]      vga_col_q;
  logic [7:0]      pos_x_q;
  logic [6:0]      pos_y_q;

  logic            entry;
  logic [CntW-1:0] pix_idx;
  int unsigned     pix_col_off;
  int unsigned     pix_row_off;
  logic            pix_border;
  logic [7:0]      pix_x;
  logic [6:0]      pix_y;
  logic [2:0]      pix_col;
  logic [8:0]      x_inc;
  logic [7:0]      y_inc;
  logic [7:0]      x_right;
  logic [7:0]      x_left;
  logic [6:0]      y_down;
  logic [6:0]      y_up;

  // Pixel for the current edge: index 0 on sweep entry, otherwise the running counter.
  always_comb begin
    entry       = (cmd != cmd_q);
    pix_idx     = entry ? '0 : cnt_q;
    pix_col_off = 32'(pix_idx) % BOX;
    pix_row_off = 32'(pix_idx) / BOX;
    pix_border  = (pix_col_off == 0) || (pix_col_off == BOX - 1) ||
                  (pix_row_off == 0) || (pix_row_off == BOX - 1);
    pix_x       = pos_x_q + 8'(pix_col_off);
    pix_y       = pos_y_q + 7'(pix_row_off);
    if (cmd == CmdClear) begin
      pix_col = BG_COLOUR;
    end else if (BorderEn && pix_border) begin
      pix_col = BD_COLOUR;
    end else begin
      pix_col = FG_COLOUR;
    end
  end

  // Clamped move targets, computed one bit wider so overflow is visible.
  always_comb begin
    x_inc   = {1'b0, pos_x_q} + {1'b0, StepX};
    y_inc   = {1'b0, pos_y_q} + {1'b0, StepY};
    x_right = (x_inc > {1'b0, XMax}) ? XMax : x_inc[7:0];
    y_down  = (y_inc > {1'b0, YMax}) ? YMax : y_inc[6:0];
    x_left  = (pos_x_q < StepX) ? 8'd0 : pos_x_q - StepX;
    y_up    = (pos_y_q < StepY) ? 7'd0 : pos_y_q - StepY;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cmd_q     <= CmdHold;
      swept_q   <= CmdHold;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      plot_q    <= 1'b0;
      vga_x_q   <= '0;
      vga_y_q   <= '0;
      vga_col_q <= '0;
      pos_x_q   <= 8'(X_INIT);
      pos_y_q   <= 7'(Y_INIT);
    end else begin
      cmd_q <= cmd;
      if (entry) begin
        case (cmd)
          CmdClear, CmdDraw: begin
            state_q   <= StSweep;
            swept_q   <= cmd;
            done_q    <= 1'b0;
            plot_q    <= 1'b1;
            vga_x_q   <= pix_x;
            vga_y_q   <= pix_y;
            vga_col_q <= pix_col;
            cnt_q     <= CntW'(1);
          end
          CmdLeft: begin
            state_q <= StIdle;
            plot_q  <= 1'b0;
            pos_x_q <= x_left;
          end
          CmdRight: begin
            state_q <= StIdle;
            plot_q  <= 1'b0;
            pos_x_q <= x_right;
          end
          CmdUp: begin
            state_q <= StIdle;
            plot_q  <= 1'b0;
            pos_y_q <= y_up;
          end
          CmdDown: begin
            state_q <= StIdle;
            plot_q  <= 1'b0;
            pos_y_q <= y_down;
          end
          default: begin
            // PREHOLD, HOLD and unknown codes: abandon any sweep, keep done flag.
            state_q <= StIdle;
            plot_q  <= 1'b0;
          end
        endcase
      end else begin
        case (state_q)
          StSweep: begin
            if (cnt_q == CntW'(NPix)) begin
              state_q <= StIdle;
              plot_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              plot_q    <= 1'b1;
              vga_x_q   <= pix_x;
              vga_y_q   <= pix_y;
              vga_col_q <= pix_col;
              cnt_q     <= cnt_q + CntW'(1);
            end
          end
          default: plot_q <= 1'b0;
        endcase
      end
    end
  end

  // A command change kills the plot strobe in the same cycle, before the edge aborts the sweep.
  assign plot    = plot_q & ~entry;
  assign done_o  = done_q & (cmd == swept_q);
  assign vga_x   = vga_x_q;
  assign vga_y   = vga_y_q;
  assign vga_col = vga_col_q;
  assign pos_x   = pos_x_q;
  assign pos_y   = pos_y_q;

  logic unused_cmds;
  assign unused_cmds = ^{CmdPrehold};

endmodule

// File: tb/tb_sprite_draw_engine.sv
// Self-checking bench for sprite_draw_engine: vector table, corner sequences, random commands
// checked against a cycles-since-entry reference model.
module tb_sprite_draw_engine;

  localparam logic [3:0] PREHOLD = 4'b0100;
  localparam logic [3:0] HOLD    = 4'b0000;
  localparam logic [3:0] CLEAR   = 4'b0001;
  localparam logic [3:0] LEFT    = 4'b0011;
  localparam logic [3:0] RIGHT   = 4'b0010;
  localparam logic [3:0] DOWN    = 4'b0110;
  localparam logic [3:0] UP      = 4'b0111;
  localparam logic [3:0] DRAW    = 4'b0101;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] cmd;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_col;
  logic       plot;
  logic       done_o;
  logic [7:0] pos_x;
  logic [6:0] pos_y;

  sprite_draw_engine dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cmd     (cmd),
    .vga_x   (vga_x),
    .vga_y   (vga_y),
    .vga_col (vga_col),
    .plot    (plot),
    .done_o  (done_o),
    .pos_x   (pos_x),
    .pos_y   (pos_y)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int plots_seen = 0;

  // Reference model: position, and age = cycles since the last CLEAR/DRAW entry (-1 = none).
  int m_prev, m_age, m_sweep, m_x, m_y;
  bit m_done;

  typedef struct {
    logic [3:0] c;
    int         cycles;
    int         ex;
    int         ey;
    int         edone;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev  = HOLD;
    m_age   = -1;
    m_done  = 1'b0;
    m_sweep = HOLD;
    m_x     = 78;
    m_y     = 58;
  endtask

  function automatic int exp_colour(input int k);
    int cx, ry;
    cx = k % 4;
    ry = k / 4;
    if (m_sweep == CLEAR) return 0;
`ifdef SPRITE_BORDER_EN
    if (cx == 0 || cx == 3 || ry == 0 || ry == 3) return 4;
`endif
    return 7;
  endfunction

  task automatic check_outputs(input logic [3:0] c);
    bit entry, exp_plot;
    int k;
    entry    = (c != m_prev);
    exp_plot = !entry && m_age >= 1 && m_age <= 16;
    chk("plot", int'(plot), int'(exp_plot));
    chk("done", int'(done_o), int'(m_done && c == m_sweep));
    chk("pos_x", int'(pos_x), m_x);
    chk("pos_y", int'(pos_y), m_y);
    if (plot) plots_seen++;
    if (exp_plot) begin
      k = m_age - 1;
      chk("vga_x", int'(vga_x), m_x + k % 4);
      chk("vga_y", int'(vga_y), m_y + k / 4);
      chk("vga_col", int'(vga_col), exp_colour(k));
    end
  endtask

  task automatic model_edge(input logic [3:0] c);
    if (c != m_prev) begin
      if (c == CLEAR || c == DRAW) begin
        m_age   = 1;
        m_sweep = c;
        m_done  = 1'b0;
      end else begin
        m_age = -1;
        if (c == RIGHT) m_x = (m_x + 1 > 156) ? 156 : m_x + 1;
        if (c == LEFT)  m_x = (m_x < 1) ? 0 : m_x - 1;
        if (c == DOWN)  m_y = (m_y + 1 > 116) ? 116 : m_y + 1;
        if (c == UP)    m_y = (m_y < 1) ? 0 : m_y - 1;
      end
    end else if (m_age >= 1) begin
      m_age++;
      if (m_age == 17) begin
        m_done = 1'b1;
        m_age  = -1;
      end
    end
    m_prev = c;
  endtask

  // Called at a negedge; drives c for one cycle, checks, advances to the next negedge.
  task automatic step(input logic [3:0] c);
    cmd = c;
    #1;
    check_outputs(c);
    @(posedge clk);
    model_edge(c);
    @(negedge clk);
  endtask

  vec_t vecs[12];
  logic [3:0] codes[10];
  logic [3:0] cur;
  int base;

  initial begin
    vecs[0]  = '{CLEAR,   17, 78, 58, 1};
    vecs[1]  = '{DRAW,    17, 78, 58, 1};
    vecs[2]  = '{UP,       5, 78, 57, 0};
    vecs[3]  = '{LEFT,     2, 77, 57, 0};
    vecs[4]  = '{DOWN,     1, 77, 58, 0};
    vecs[5]  = '{RIGHT,    3, 78, 58, 0};
    vecs[6]  = '{HOLD,     2, 78, 58, 0};
    vecs[7]  = '{DRAW,    10, 78, 58, 0};
    vecs[8]  = '{PREHOLD,  1, 78, 58, 0};
    vecs[9]  = '{4'b1000,  2, 78, 58, 0};
    vecs[10] = '{CLEAR,   16, 78, 58, 0};
    vecs[11] = '{DRAW,    17, 78, 58, 1};
    codes = '{PREHOLD, HOLD, CLEAR, LEFT, RIGHT, DOWN, UP, DRAW, 4'b1000, 4'b1111};

    reset_n = 1'b0;
    cmd     = HOLD;
    model_reset();
    #12;
    chk("rst_plot", int'(plot), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_vga_x", int'(vga_x), 0);
    chk("rst_vga_y", int'(vga_y), 0);
    chk("rst_vga_col", int'(vga_col), 0);
    chk("rst_pos_x", int'(pos_x), 78);
    chk("rst_pos_y", int'(pos_y), 58);

    // Release reset with CLEAR already present so it counts as a new command.
    @(negedge clk);
    cmd     = CLEAR;
    reset_n = 1'b1;
    foreach (vecs[i]) begin
      for (int n = 0; n < vecs[i].cycles; n++) step(vecs[i].c);
      cmd = vecs[i].c;
      #1;
      chk("tbl_pos_x", int'(pos_x), vecs[i].ex);
      chk("tbl_pos_y", int'(pos_y), vecs[i].ey);
      chk("tbl_done", int'(done_o), vecs[i].edone);
      @(negedge clk);
      model_edge(vecs[i].c);
    end

    // Clamping at every screen edge, one update per entry.
    for (int n = 0; n < 80; n++) begin step(RIGHT); step(HOLD); end
    chk("clamp_right", int'(pos_x), 156);
    for (int n = 0; n < 3; n++) step(RIGHT);
    chk("clamp_right_hold", int'(pos_x), 156);
    for (int n = 0; n < 160; n++) begin step(LEFT); step(HOLD); end
    step(LEFT);
    chk("clamp_left", int'(pos_x), 0);
    for (int n = 0; n < 70; n++) begin step(DOWN); step(HOLD); end
    chk("clamp_down", int'(pos_y), 116);
    for (int n = 0; n < 120; n++) begin step(UP); step(HOLD); end
    chk("clamp_up", int'(pos_y), 0);
    for (int n = 0; n < 10; n++) begin step(RIGHT); step(DOWN); step(HOLD); end
    chk("move_to_x", int'(pos_x), 10);
    chk("move_to_y", int'(pos_y), 10);

    // Abort a DRAW after 6 pixels, then redraw the full box from the first pixel.
    for (int n = 0; n < 7; n++) step(DRAW);
    cmd = HOLD;
    #1;
    chk("abort_plot", int'(plot), 0);
    chk("abort_done", int'(done_o), 0);
    @(posedge clk);
    model_edge(HOLD);
    @(negedge clk);
    step(DRAW);
    #1;
    chk("redraw_first_x", int'(vga_x), 10);
    chk("redraw_first_y", int'(vga_y), 10);
    base = plots_seen;
    for (int n = 0; n < 17; n++) step(DRAW);
    chk("redraw_count", plots_seen - base, 16);
    chk("redraw_done", int'(done_o), 1);

    // Asynchronous reset in the middle of a sweep.
    for (int n = 0; n < 5; n++) step(CLEAR);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_plot", int'(plot), 0);
    chk("midrst_done", int'(done_o), 0);
    chk("midrst_pos_x", int'(pos_x), 78);
    chk("midrst_vga_x", int'(vga_x), 0);
    model_reset();
    cmd = HOLD;
    @(negedge clk);
    reset_n = 1'b1;

    // Random commands, mostly held long enough for sweeps to finish.
    cur = HOLD;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 9) == 0) cur = codes[$urandom_range(0, 9)];
      step(cur);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
